// File: rtl/cam_pkg.sv
// cam_pkg: shared types, widths and RGB565->RGB444 conversion for the camera capture front-end
package cam_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_LO} cap_state_e;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
  function automatic rgb444_t rgb565_to_444(input logic [15:0] p);
    rgb565_to_444 = {p[15:12], p[10:7], p[4:1]};
  endfunction
endpackage

// File: rtl/cam_sync_bit.sv
// cam_sync_bit: STAGES-deep W-bit synchronizer chain (clk_i, async active-low rst_n_i, d in, q out)
module cam_sync_bit #(
  parameter int STAGES = 2,
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] chain;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: oversampled OV7670 bus (pclk/href/vsync/data in) -> RGB444 pixel strobes with sof/line/frame markers, x/y, frame count, sticky err
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           capture_en_i,
  input  logic           pclk_i,
  input  logic           href_i,
  input  logic           vsync_i,
  input  logic [7:0]     data_i,
  output logic           pix_valid_o,
  output logic [11:0]    pix_data_o,
  output logic           pix_sof_o,
  output logic           line_end_o,
  output logic           frame_done_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [7:0]     frame_cnt_o,
  output logic           err_o
);
  logic p_s, h_s, v_s;
  logic [7:0] d_s;
  cam_sync_bit #(.STAGES(SYNC_STAGES), .W(1)) u_pclk  (.clk_i, .rst_n_i, .d(pclk_i),  .q(p_s));
  cam_sync_bit #(.STAGES(SYNC_STAGES), .W(1)) u_href  (.clk_i, .rst_n_i, .d(href_i),  .q(h_s));
  cam_sync_bit #(.STAGES(SYNC_STAGES), .W(1)) u_vsync (.clk_i, .rst_n_i, .d(vsync_i), .q(v_s));
  cam_sync_bit #(.STAGES(SYNC_STAGES), .W(8)) u_data  (.clk_i, .rst_n_i, .d(data_i),  .q(d_s));
  logic p_l, h_l, v_l, prise_q, hfall_q, vrise_q, vfall_q, href_q;
  logic [7:0] data_q, hi_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      {p_l, h_l, v_l, prise_q, hfall_q, vrise_q, vfall_q, href_q} <= '0;
      data_q <= '0;
    end else begin
      p_l <= p_s;
      h_l <= h_s;
      v_l <= v_s;
      prise_q <= p_s & ~p_l;
      hfall_q <= ~h_s & h_l;
      vrise_q <= v_s & ~v_l;
      vfall_q <= ~v_s & v_l;
      href_q <= h_s;
      data_q <= d_s;
    end
  cap_state_e state, state_n;
  logic start, latch_hi, pix_try, pix_ok, lend, fdone, odd;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic line_pix, sof_pend;
  // vsync rise outranks any same-cycle line event, but the line end is still reported
  always_comb begin
    state_n = state;
    start = 1'b0;
    latch_hi = 1'b0;
    pix_try = 1'b0;
    lend = 1'b0;
    fdone = 1'b0;
    odd = 1'b0;
    if (!capture_en_i) state_n = WAIT_FRAME;
    else if (vrise_q) begin
      state_n = WAIT_FRAME;
      fdone = state != WAIT_FRAME;
      lend = hfall_q && state != WAIT_FRAME;
    end else
      case (state)
        WAIT_FRAME: if (vfall_q) begin
          state_n = WAIT_LINE;
          start = 1'b1;
        end
        WAIT_LINE: if (hfall_q) lend = 1'b1;
          else if (prise_q && href_q) begin
            latch_hi = 1'b1;
            state_n = BYTE_LO;
          end
        BYTE_LO: if (hfall_q) begin
            lend = 1'b1;
            odd = 1'b1;
            state_n = WAIT_LINE;
          end else if (prise_q && href_q) begin
            pix_try = 1'b1;
            state_n = WAIT_LINE;
          end
        default: state_n = WAIT_FRAME;
      endcase
  end
  assign pix_ok = pix_try && x_cnt != X_W'(H_ACTIVE) && y_cnt != Y_W'(V_ACTIVE);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= WAIT_FRAME;
    else state <= state_n;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      {pix_valid_o, pix_sof_o, line_end_o, frame_done_o, err_o, line_pix, sof_pend} <= '0;
      pix_data_o <= '0;
      x_o <= '0;
      y_o <= '0;
      frame_cnt_o <= '0;
      hi_q <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      pix_valid_o <= pix_ok;
      pix_sof_o <= pix_ok & sof_pend;
      line_end_o <= lend;
      frame_done_o <= fdone;
      if (latch_hi) hi_q <= data_q;
      if (pix_ok) begin
        pix_data_o <= rgb565_to_444({hi_q, data_q});
        x_o <= x_cnt;
        y_o <= y_cnt;
        x_cnt <= x_cnt + X_W'(1);
        line_pix <= 1'b1;
        sof_pend <= 1'b0;
      end
      if (start) begin
        x_cnt <= '0;
        y_cnt <= '0;
        line_pix <= 1'b0;
        sof_pend <= 1'b1;
      end
      if (lend) begin
        x_cnt <= '0;
        line_pix <= 1'b0;
        if (line_pix && y_cnt != Y_W'(V_ACTIVE)) y_cnt <= y_cnt + Y_W'(1);
      end
      if (fdone) begin
        frame_cnt_o <= frame_cnt_o + 8'd1;
        y_cnt <= '0;
      end
      if (odd || (pix_try && !pix_ok)) err_o <= 1'b1;
    end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture: randomized frame stimulus checked against a line/pixel-level reference model
module tb_cam_pixel_capture;
  localparam int H = 4;
  localparam int V = 2;
  localparam int SS = 2;
  logic clk_i = 0, rst_n_i = 0, capture_en_i = 0, pclk_i = 0, href_i = 0, vsync_i = 1;
  logic [7:0] data_i = 0;
  logic pix_valid_o, pix_sof_o, line_end_o, frame_done_o, err_o;
  logic [11:0] pix_data_o;
  logic [9:0] x_o;
  logic [8:0] y_o;
  logic [7:0] frame_cnt_o;
  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .capture_en_i(capture_en_i), .pclk_i(pclk_i),
    .href_i(href_i), .vsync_i(vsync_i), .data_i(data_i), .pix_valid_o(pix_valid_o),
    .pix_data_o(pix_data_o), .pix_sof_o(pix_sof_o), .line_end_o(line_end_o),
    .frame_done_o(frame_done_o), .x_o(x_o), .y_o(y_o), .frame_cnt_o(frame_cnt_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [11:0] d;
    int x;
    int y;
    bit sof;
  } px_t;
  px_t exp_q[$];
  int checks = 0, passed = 0;
  int cyc = 0, last_rise = 0, le_cnt = 0, fd_cnt = 0;
  int mfc = 0;
  bit merr = 0;
  logic [7:0] lb [4][12];
  int ln [4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) begin
    le_cnt += int'(line_end_o);
    fd_cnt += int'(frame_done_o);
    if (pix_valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_pix", 1, 0);
      else begin
        px_t e;
        e = exp_q.pop_front();
        chk("pix_data", pix_data_o, e.d);
        chk("pix_x", x_o, e.x);
        chk("pix_y", y_o, e.y);
        chk("pix_sof", pix_sof_o, e.sof);
        chk("latency", cyc - last_rise, SS + 2);
      end
    end
  end
  function automatic logic [11:0] conv(input logic [7:0] hi, input logic [7:0] lo);
    int p;
    p = hi * 256 + lo;
    return 12'((((p >> 12) & 15) << 8) | (((p >> 7) & 15) << 4) | ((p >> 1) & 15));
  endfunction
  function automatic void model_frame(input int nl);
    int y;
    bit first;
    y = 0;
    first = 1;
    for (int l = 0; l < nl; l++) begin
      int emitted;
      emitted = 0;
      if (ln[l] % 2 != 0) merr = 1;
      for (int p = 0; p < ln[l] / 2; p++)
        if (y >= V || p >= H) merr = 1;
        else begin
          exp_q.push_back('{conv(lb[l][2*p], lb[l][2*p+1]), p, y, first});
          first = 0;
          emitted++;
        end
      if (emitted > 0) y++;
    end
    mfc = (mfc + 1) % 256;
  endfunction
  task automatic clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  task automatic pbeat(input logic [7:0] d, input logic h);
    data_i = d;
    href_i = h;
    pclk_i = 0;
    clks(4);
    pclk_i = 1;
    last_rise = cyc;
    clks(4);
  endtask
  task automatic run_frame(input int nl, input bit cap, input bit simul);
    int le0, fd0;
    le0 = le_cnt;
    fd0 = fd_cnt;
    if (cap) model_frame(nl);
    capture_en_i = cap;
    vsync_i = 1;
    pbeat(0, 0);
    pbeat(0, 0);
    vsync_i = 0;
    pbeat(0, 0);
    pbeat(0, 0);
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < ln[l]; b++) pbeat(lb[l][b], 1);
      if (!cap && l == 0) capture_en_i = 1;
      if (!(simul && l == nl - 1)) begin
        pbeat(0, 0);
        pbeat(0, 0);
      end
    end
    vsync_i = 1;
    pbeat(0, 0);
    pbeat(0, 0);
    chk("line_end_count", le_cnt - le0, cap ? nl : 0);
    chk("frame_done_count", fd_cnt - fd0, int'(cap));
    chk("frame_cnt", frame_cnt_o, mfc);
    chk("err", err_o, merr);
    chk("pix_left", exp_q.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end
  initial begin
    int fd0;
    clks(3);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_pix_data", pix_data_o, 0);
    chk("rst_sof", pix_sof_o, 0);
    chk("rst_line_end", line_end_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_x", x_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_err", err_o, 0);
    rst_n_i = 1;
    clks(4);
    ln[0] = 4; lb[0][0] = 8'hF8; lb[0][1] = 8'h00; lb[0][2] = 8'h07; lb[0][3] = 8'hE0;
    ln[1] = 4; lb[1][0] = 8'h12; lb[1][1] = 8'h34; lb[1][2] = 8'h56; lb[1][3] = 8'h78;
    run_frame(2, 1, 0);
    ln[0] = 3; lb[0][0] = 8'hA5; lb[0][1] = 8'h5A; lb[0][2] = 8'hFF;
    ln[1] = 4; lb[1][0] = 8'hC3; lb[1][1] = 8'h3C; lb[1][2] = 8'h81; lb[1][3] = 8'h18;
    run_frame(2, 1, 0);
    fd0 = fd_cnt;
    capture_en_i = 1;
    vsync_i = 1;
    pbeat(0, 0);
    pbeat(0, 0);
    vsync_i = 0;
    pbeat(0, 0);
    pbeat(0, 0);
    pbeat(8'hAA, 1);
    data_i = 8'hBB;
    pclk_i = 0;
    clks(2);
    rst_n_i = 0;
    #1;
    chk("arst_frame_cnt", frame_cnt_o, 0);
    chk("arst_pix_data", pix_data_o, 0);
    chk("arst_y", y_o, 0);
    chk("arst_err", err_o, 0);
    clks(2);
    pclk_i = 1;
    last_rise = cyc;
    clks(2);
    rst_n_i = 1;
    clks(2);
    pbeat(8'hCC, 1);
    pbeat(8'hDD, 1);
    pbeat(0, 0);
    pbeat(0, 0);
    vsync_i = 1;
    pbeat(0, 0);
    pbeat(0, 0);
    mfc = 0;
    merr = 0;
    chk("arst_frame_done", fd_cnt - fd0, 0);
    chk("arst_frame_cnt_after", frame_cnt_o, 0);
    ln[0] = 4; lb[0][0] = 8'h11; lb[0][1] = 8'h22; lb[0][2] = 8'h33; lb[0][3] = 8'h44;
    run_frame(1, 0, 0);
    ln[0] = 4; lb[0][0] = 8'hFF; lb[0][1] = 8'hFF; lb[0][2] = 8'h80; lb[0][3] = 8'h01;
    run_frame(1, 1, 0);
    for (int l = 0; l < 3; l++) begin
      ln[l] = 12;
      for (int b = 0; b < 12; b++) lb[l][b] = 8'($urandom);
    end
    run_frame(3, 1, 0);
    for (int f = 0; f < 20; f++) begin
      int nl;
      bit simul;
      nl = $urandom_range(1, 3);
      simul = $urandom_range(0, 3) == 0;
      for (int l = 0; l < nl; l++) begin
        ln[l] = $urandom_range(1, 12);
        for (int b = 0; b < 12; b++) lb[l][b] = 8'($urandom);
      end
      if (simul) ln[nl-1] = 2 * $urandom_range(1, 6);
      run_frame(nl, $urandom_range(0, 4) != 0, simul);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
